dm_responder: RTL and testbench
===============================

// Module: dm_responder
// PURPOSE
//  Responder end of the CPU data-memory request interface; the core is the initiator.
//  Services load/store requests with a configurable wait-state latency and a single-cycle ack.
//  Handles byte, halfword and word lanes, sign/zero extension and alignment/range errors.
//  Sits between the core's LSU and the backing word array; replaces the zero-latency DM.
// PARAMETERS
//  DEPTH_WORDS  3072  words of storage; valid byte addresses are 0 .. DEPTH_WORDS*4-1
//  WAIT_CYCLES  2     extra cycles between request accept and ack (0 allowed)
// PORTS
//  clk    in   1   single clock; all state updates on rising edge
//  reset  in   1   synchronous, active-high reset
//  req    in   1   request valid; sampled only in IDLE
//  we     in   1   1 = store, 0 = load
//  size   in   2   00 byte, 01 half, 10 word; 11 is reserved and flags err
//  sext   in   1   loads only: 1 sign-extend, 0 zero-extend
//  addr   in   32  byte address
//  wdata  in   32  store data; low byte/half used for sb/sh
//  pc     in   32  PC of issuing instruction, used in write trace only
//  ack    out  1   one-cycle response strobe
//  err    out  1   valid with ack: misaligned / out-of-range / reserved size
//  rdata  out  32  load result, valid with ack; held until next ack
//  busy   out  1   high in WAIT and RESP
// BEHAVIOUR
//  Reset: state=IDLE, ack=0, err=0, rdata=0, busy=0, all words cleared to 0.
//  FSM states: IDLE, WAIT, RESP.
//   IDLE: if req=1, latch we/size/sext/addr/wdata/pc and load cnt=WAIT_CYCLES.
//    Go to WAIT if WAIT_CYCLES>0, else go to RESP.
//   WAIT: cnt decrements each cycle; when cnt reaches 1, go to RESP.
//   RESP: ack=1 for exactly one cycle, then IDLE unconditionally; req is ignored.
//  Latency: req sampled at edge t -> ack high during cycle t+WAIT_CYCLES+1.
//  Commit: on the edge entering RESP, evaluate err, write the array (store, no err)
//   or register rdata (load). The array is never written in any other cycle.
//  Handshake: the requester holds req and payload stable until ack, then drops req
//   the cycle after ack. req still high in the IDLE after RESP starts a new request.
//  Error rules:
//   size=11 -> err.
//   Word with addr[1:0]!=0, or half with addr[0]!=0 -> err.
//   addr >= DEPTH_WORDS*4 -> err.
//   On err: no write; rdata=0.
//  Lanes (little-endian): word index = addr[31:2], lane = addr[1:0].
//   Byte read: bits [8*lane+7 -: 8]. Half read: lane 0 -> [15:0], lane 2 -> [31:16].
//   Loads are extended to 32 bits per sext; stores do a read-modify-write that
//   replaces only the addressed lanes.
//  Store trace on each committed write:
//   $display("@%h: *%h <= %h", pc, {addr[31:2],2'b00}, merged_word).
//  Reset mid-operation (WAIT or RESP): abort, no write, no ack, return to IDLE.
// STRUCTURE
//  Shared defines header: SZ_BYTE/SZ_HALF/SZ_WORD encodings and FSM state codes;
//   the LSU uses the same encodings.
//  Sub-module dm_lane_align (combinational): word + lane + size + sext -> rdata;
//   word + wdata + lane + size -> merged word.
//  FSM, counter, error check and array live in dm_responder.
// TESTING
//  1. WAIT_CYCLES=2: sw addr 0x10 data 0x12345678, then lw 0x10
//     -> each ack exactly 3 cycles after accept; rdata=0x12345678; err=0.
//  2. Word 0x10 = 0x12345678. sb 0xAB at 0x11, then lw 0x10 -> 0x1234AB78.
//     lb 0x11 sext=1 -> 0xFFFFFFAB. lbu 0x11 -> 0x000000AB.
//  3. Word 0x10 = 0x8001xxxx. lh 0x12 sext=1 -> 0xFFFF8001. lhu 0x12 -> 0x00008001.
//  4. lw 0x13, sh 0x11, sw at 0x3000 (DEPTH 3072), size=11
//     -> err=1 with ack, rdata=0, target words unchanged.
//  5. reset asserted in WAIT during a sw -> no ack, word unchanged, busy=0
//     next cycle, new req accepted on the following edge.
//  6. WAIT_CYCLES=0 with req held high across ack -> ack high every 2nd cycle;
//     each response reflects its latched request.

Source files
------------

// File: rtl/dm_responder_pkg.sv
// Shared encodings for the data-memory responder and the LSU that talks to it.
// Holds the access-size codes, the FSM state codes, the latched request record
// and the access legality check.
package dm_responder_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
  } dm_req_t;

  // An access is illegal for a reserved size, a misaligned half/word, or an
  // address past the end of the backing array.
  function automatic logic access_err(input logic [1:0]  size,
                                      input logic [31:0] addr,
                                      input logic [31:0] limit_bytes);
    logic e;
    e = 1'b0;
    case (size)
      SZ_HALF: e = addr[0];
      SZ_WORD: e = (addr[1:0] != 2'b00);
      SZ_RSVD: e = 1'b1;
      default: e = 1'b0;
    endcase
    if (addr >= limit_bytes) e = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/dm_responder_if.sv
// Core <-> data-memory request interface. The core (master) drives the request
// and payload; the responder (slave) returns ack/err/rdata/busy plus a
// write-trace record that is valid together with the ack of a committed store.
interface dm_responder_if;
  import dm_responder_pkg::*;

  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] pc;

  logic        ack;
  logic        err;
  logic [31:0] rdata;
  logic        busy;

  logic        trc_valid;
  logic [31:0] trc_pc;
  logic [31:0] trc_addr;
  logic [31:0] trc_data;

  modport master (
    output req, we, size, sext, addr, wdata, pc,
    input  ack, err, rdata, busy, trc_valid, trc_pc, trc_addr, trc_data
  );

  modport slave (
    input  req, we, size, sext, addr, wdata, pc,
    output ack, err, rdata, busy, trc_valid, trc_pc, trc_addr, trc_data
  );

endinterface

// File: rtl/dm_lane_align.sv
// Little-endian lane steering between a 32-bit storage word and the core.
// Loads pick the addressed byte/half and extend it; stores merge the low
// byte/half of wdata into the addressed lanes of the old word.
module dm_lane_align
  import dm_responder_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed lanes and extend them to a full load result
  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: rdata = {{24{sext & byte_sel[7]}}, byte_sel};
      SZ_HALF: rdata = {{16{sext & half_sel[15]}}, half_sel};
      SZ_WORD: rdata = word;
      default: rdata = '0;
    endcase
  end

  // Read-modify-write: replace only the lanes the store addresses
  always_comb begin
    merged = word;
    case (size)
      SZ_BYTE: merged[{lane, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (lane[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      SZ_WORD: merged = wdata;
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: accepts one load/store at a time, waits WAIT_CYCLES,
// then commits and acks for a single cycle. A per-word valid bit makes reset
// clear the whole array in one cycle; words never written since reset read 0.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 3072,
  parameter int WAIT_CYCLES = 2
) (
  input logic          clk,
  input logic          reset,
  dm_responder_if.slave bus
);

  localparam int               CNT_W       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int               IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0]      LIMIT_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(WAIT_CYCLES);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  dm_req_t                req_q, req_d;
  logic                   ack_q, ack_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [DEPTH_WORDS-1:0] valid_q, valid_d;
  logic                   trc_valid_q, trc_valid_d;
  logic [31:0]            trc_pc_q, trc_pc_d;
  logic [31:0]            trc_addr_q, trc_addr_d;
  logic [31:0]            trc_data_q, trc_data_d;

  logic [31:0]            mem [DEPTH_WORDS];

  dm_req_t                cur;
  logic                   cur_err;
  logic                   in_range;
  logic [IDX_W-1:0]       word_idx;
  logic [31:0]            rd_word;
  logic [31:0]            ld_data;
  logic [31:0]            merged;
  logic                   commit;
  logic                   do_write;

  // With zero wait states the commit happens on the accept edge, so the
  // active request comes straight from the bus while IDLE
  always_comb begin
    cur = req_q;
    if (state_q == ST_IDLE) begin
      cur.we    = bus.we;
      cur.size  = bus.size;
      cur.sext  = bus.sext;
      cur.addr  = bus.addr;
      cur.wdata = bus.wdata;
      cur.pc    = bus.pc;
    end
  end

  assign in_range = (cur.addr < LIMIT_BYTES);
  assign word_idx = cur.addr[IDX_W+1:2];
  assign cur_err  = access_err(cur.size, cur.addr, LIMIT_BYTES);
  assign rd_word  = (in_range && valid_q[word_idx]) ? mem[word_idx] : 32'h0;

  dm_lane_align u_align (
    .word   (rd_word),
    .lane   (cur.addr[1:0]),
    .size   (cur.size),
    .sext   (cur.sext),
    .wdata  (cur.wdata),
    .rdata  (ld_data),
    .merged (merged)
  );

  // Next-state, counter and commit decisions; outputs are registered from these
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    ack_d       = 1'b0;
    err_d       = err_q;
    rdata_d     = rdata_q;
    valid_d     = valid_q;
    trc_valid_d = 1'b0;
    trc_pc_d    = trc_pc_q;
    trc_addr_d  = trc_addr_q;
    trc_data_d  = trc_data_q;
    commit      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          req_d = cur;
          cnt_d = CNT_LOAD;
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_RESP;
            commit  = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RESP;
          commit  = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    do_write = commit && cur.we && !cur_err;

    if (commit) begin
      ack_d = 1'b1;
      err_d = cur_err;
      if (cur_err)     rdata_d = 32'h0;
      else if (!cur.we) rdata_d = ld_data;
    end

    if (do_write) begin
      valid_d[word_idx] = 1'b1;
      trc_valid_d       = 1'b1;
      trc_pc_d          = cur.pc;
      trc_addr_d        = {cur.addr[31:2], 2'b00};
      trc_data_d        = merged;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // FSM and registered outputs; reset aborts any request in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      rdata_q     <= '0;
      valid_q     <= '0;
      trc_valid_q <= 1'b0;
      trc_pc_q    <= '0;
      trc_addr_q  <= '0;
      trc_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      rdata_q     <= rdata_d;
      valid_q     <= valid_d;
      trc_valid_q <= trc_valid_d;
      trc_pc_q    <= trc_pc_d;
      trc_addr_q  <= trc_addr_d;
      trc_data_q  <= trc_data_d;
    end
  end

  // Backing word storage, written only on the edge that enters RESP
  always_ff @(posedge clk) begin
    if (!reset && do_write) mem[word_idx] <= merged;
  end

  assign bus.ack       = ack_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.trc_valid = trc_valid_q;
  assign bus.trc_pc    = trc_pc_q;
  assign bus.trc_addr  = trc_addr_q;
  assign bus.trc_data  = trc_data_q;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: one instance with two wait states, one with none.
// Expected values come from a byte-addressed reference memory and plain
// arithmetic on sizes, alignment and extension.
module tb_dm_responder;
  import dm_responder_pkg::*;

  localparam int DEPTH = 3072;

  logic clk = 1'b0;
  logic resetA;
  logic resetB;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] mdlA [longint];
  logic [7:0] mdlB [longint];

  always #5 clk = ~clk;

  dm_responder_if busA ();
  dm_responder_if busB ();

  dm_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dutA (
    .clk   (clk),
    .reset (resetA),
    .bus   (busA)
  );

  dm_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dutB (
    .clk   (clk),
    .reset (resetB),
    .bus   (busB)
  );

  // Store trace of every committed write, as the zero-latency DM used to print
  always @(negedge clk) begin
    if (busA.trc_valid === 1'b1) $display("@%h: *%h <= %h", busA.trc_pc, busA.trc_addr, busA.trc_data);
    if (busB.trc_valid === 1'b1) $display("@%h: *%h <= %h", busB.trc_pc, busB.trc_addr, busB.trc_data);
  end

  // Count one comparison and report it when observed and expected differ
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] getByte(input bit useB, input longint a);
    if (useB) return mdlB.exists(a) ? mdlB[a] : 8'h00;
    return mdlA.exists(a) ? mdlA[a] : 8'h00;
  endfunction

  task automatic setByte(input bit useB, input longint a, input logic [7:0] d);
    if (useB) mdlB[a] = d;
    else      mdlA[a] = d;
  endtask

  function automatic bit modelErr(input logic [1:0] size, input logic [31:0] addr);
    longint n;
    if (size == 2'b11) return 1'b1;
    n = longint'(1) << size;
    if ((longint'(addr) % n) != 0) return 1'b1;
    return longint'(addr) >= longint'(DEPTH) * 4;
  endfunction

  function automatic logic [31:0] modelLoad(input bit useB, input logic [1:0] size,
                                            input bit sext, input logic [31:0] addr);
    longint n, v;
    n = longint'(1) << size;
    v = 0;
    for (int i = 0; i < n; i++) v += longint'(getByte(useB, longint'(addr) + i)) << (8 * i);
    if (sext && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  // Apply one access to the reference memory and return what the DUT must show
  task automatic modelAccess(input bit useB, input bit we, input logic [1:0] size, input bit sext,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output bit expErr, output logic [31:0] expRd, output logic [31:0] expWord);
    longint n;
    logic [31:0] d;
    expErr  = modelErr(size, addr);
    expRd   = 32'h0;
    expWord = 32'h0;
    if (!expErr && !we) expRd = modelLoad(useB, size, sext, addr);
    if (!expErr && we) begin
      n = longint'(1) << size;
      d = wdata;
      for (int i = 0; i < n; i++) begin
        setByte(useB, longint'(addr) + i, d[7:0]);
        d = d >> 8;
      end
      expWord = modelLoad(useB, 2'b10, 1'b0, addr & 32'hFFFF_FFFC);
    end
  endtask

  task automatic pickOp(output bit we, output logic [1:0] size, output bit sext,
                        output logic [31:0] addr, output logic [31:0] wdata);
    we    = $urandom_range(0, 1) == 1;
    size  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
    sext  = $urandom_range(0, 1) == 1;
    addr  = ($urandom_range(0, 4) == 0) ? 32'h2FF8 + $urandom_range(0, 15) : 32'h40 + $urandom_range(0, 15);
    wdata = $urandom;
  endtask

  // One full request on the two-wait-state DUT, starting and ending on a negedge
  task automatic applyStimulus(input string tag, input bit we, input logic [1:0] size, input bit sext,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] got);
    bit          expErr;
    logic [31:0] expRd, expWord, pc;
    int          lat;
    pc = 32'h1000 + 32'($urandom_range(0, 255) << 2);
    modelAccess(1'b0, we, size, sext, addr, wdata, expErr, expRd, expWord);
    busA.req   = 1'b1;
    busA.we    = we;
    busA.size  = size;
    busA.sext  = sext;
    busA.addr  = addr;
    busA.wdata = wdata;
    busA.pc    = pc;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) checkOutput({tag, ".busy"}, 32'(busA.busy), 32'd1);
    end while (busA.ack !== 1'b1 && lat < 10);
    checkOutput({tag, ".latency"}, 32'(lat), 32'd3);
    checkOutput({tag, ".err"}, 32'(busA.err), 32'(expErr));
    if (!we || expErr) checkOutput({tag, ".rdata"}, busA.rdata, expRd);
    checkOutput({tag, ".trc_valid"}, 32'(busA.trc_valid), 32'(we && !expErr));
    if (we && !expErr) begin
      checkOutput({tag, ".trc_word"}, busA.trc_data, expWord);
      checkOutput({tag, ".trc_addr"}, busA.trc_addr, addr & 32'hFFFF_FFFC);
      checkOutput({tag, ".trc_pc"}, busA.trc_pc, pc);
    end
    got = busA.rdata;
    busA.req = 1'b0;
    @(negedge clk);
    checkOutput({tag, ".ack_pulse"}, 32'(busA.ack), 32'd0);
    checkOutput({tag, ".idle"}, 32'(busA.busy), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    bit          eWe, eErr, oWe, oSext;
    logic [1:0]  oSize;
    logic [31:0] eRd, eWord, oAddr, oData;

    resetA = 1'b1;
    resetB = 1'b1;
    busA.req = 1'b0; busA.we = 1'b0; busA.size = 2'b00; busA.sext = 1'b0;
    busA.addr = '0; busA.wdata = '0; busA.pc = '0;
    busB.req = 1'b0; busB.we = 1'b0; busB.size = 2'b00; busB.sext = 1'b0;
    busB.addr = '0; busB.wdata = '0; busB.pc = '0;
    repeat (3) @(negedge clk);
    resetA = 1'b0;
    resetB = 1'b0;
    @(negedge clk);
    checkOutput("rst.ack", 32'(busA.ack), 32'd0);
    checkOutput("rst.err", 32'(busA.err), 32'd0);
    checkOutput("rst.rdata", busA.rdata, 32'd0);
    checkOutput("rst.busy", 32'(busA.busy), 32'd0);
    checkOutput("rstB.ack", 32'(busB.ack), 32'd0);
    checkOutput("rstB.busy", 32'(busB.busy), 32'd0);

    $display("[TB] directed word/byte/half accesses");
    applyStimulus("t1.sw", 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h1234_5678, rd);
    applyStimulus("t1.lw", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, rd);
    checkOutput("t1.lw.lit", rd, 32'h1234_5678);
    applyStimulus("t2.sb", 1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h5555_55AB, rd);
    applyStimulus("t2.lw", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, rd);
    checkOutput("t2.lw.lit", rd, 32'h1234_AB78);
    applyStimulus("t2.lb", 1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0, rd);
    checkOutput("t2.lb.lit", rd, 32'hFFFF_FFAB);
    applyStimulus("t2.lbu", 1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0, rd);
    checkOutput("t2.lbu.lit", rd, 32'h0000_00AB);
    applyStimulus("t3.sh", 1'b1, SZ_HALF, 1'b0, 32'h12, 32'hDEAD_8001, rd);
    applyStimulus("t3.lh", 1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0, rd);
    checkOutput("t3.lh.lit", rd, 32'hFFFF_8001);
    applyStimulus("t3.lhu", 1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, rd);
    checkOutput("t3.lhu.lit", rd, 32'h0000_8001);

    $display("[TB] error cases and array boundary");
    applyStimulus("t4.lw13", 1'b0, SZ_WORD, 1'b0, 32'h13, 32'h0, rd);
    applyStimulus("t4.sh11", 1'b1, SZ_HALF, 1'b0, 32'h11, 32'hFFFF_FFFF, rd);
    applyStimulus("t4.sw3000", 1'b1, SZ_WORD, 1'b0, 32'h3000, 32'hCAFE_F00D, rd);
    applyStimulus("t4.rsvd", 1'b0, SZ_RSVD, 1'b0, 32'h10, 32'h0, rd);
    applyStimulus("t4.lw10", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, rd);
    checkOutput("t4.unchanged", rd, 32'h8001_AB78);
    applyStimulus("t4.swlast", 1'b1, SZ_WORD, 1'b0, 32'h2FFC, 32'hA5A5_0FF0, rd);
    applyStimulus("t4.lwlast", 1'b0, SZ_WORD, 1'b0, 32'h2FFC, 32'h0, rd);
    checkOutput("t4.lwlast.lit", rd, 32'hA5A5_0FF0);

    $display("[TB] reset during wait");
    busA.req = 1'b1; busA.we = 1'b1; busA.size = SZ_WORD; busA.sext = 1'b0;
    busA.addr = 32'h20; busA.wdata = 32'h7777_7777; busA.pc = 32'h2000;
    @(negedge clk);
    checkOutput("t5.busy", 32'(busA.busy), 32'd1);
    resetA   = 1'b1;
    busA.req = 1'b0;
    @(negedge clk);
    resetA = 1'b0;
    mdlA.delete();
    checkOutput("t5.ack", 32'(busA.ack), 32'd0);
    checkOutput("t5.busy0", 32'(busA.busy), 32'd0);
    checkOutput("t5.trc", 32'(busA.trc_valid), 32'd0);
    applyStimulus("t5.lw20", 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, rd);
    checkOutput("t5.nowrite", rd, 32'h0);
    applyStimulus("t5.lw10", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, rd);

    $display("[TB] random accesses, two wait states");
    for (int k = 0; k < 40; k++) begin
      pickOp(oWe, oSize, oSext, oAddr, oData);
      applyStimulus("rnd", oWe, oSize, oSext, oAddr, oData, rd);
    end

    $display("[TB] back-to-back accesses, zero wait states");
    pickOp(oWe, oSize, oSext, oAddr, oData);
    busB.req = 1'b1; busB.we = oWe; busB.size = oSize; busB.sext = oSext;
    busB.addr = oAddr; busB.wdata = oData; busB.pc = $urandom;
    eWe = oWe;
    modelAccess(1'b1, oWe, oSize, oSext, oAddr, oData, eErr, eRd, eWord);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checkOutput("b2b.ack", 32'(busB.ack), 32'd1);
      checkOutput("b2b.err", 32'(busB.err), 32'(eErr));
      if (!eWe || eErr) checkOutput("b2b.rdata", busB.rdata, eRd);
      checkOutput("b2b.trc_valid", 32'(busB.trc_valid), 32'(eWe && !eErr));
      if (eWe && !eErr) checkOutput("b2b.trc_word", busB.trc_data, eWord);
      if (k < 15) begin
        pickOp(oWe, oSize, oSext, oAddr, oData);
        busB.we = oWe; busB.size = oSize; busB.sext = oSext;
        busB.addr = oAddr; busB.wdata = oData; busB.pc = $urandom;
        eWe = oWe;
        modelAccess(1'b1, oWe, oSize, oSext, oAddr, oData, eErr, eRd, eWord);
      end else begin
        busB.req = 1'b0;
      end
      @(negedge clk);
      checkOutput("b2b.gap", 32'(busB.ack), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
